// File: rtl/bcd_pkg.sv
// bcd_pkg: shared states, widths and the decimal priority encoder for the BCD key path.
package bcd_pkg;
  localparam int NUM_DIGITS = 10;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESENT, RELEASE} state_t;
  function automatic logic [BCD_W-1:0] prio_encode(input logic [NUM_DIGITS-1:0] v);
    logic [BCD_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[i]) c = BCD_W'(i);
    return c;
  endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: 2-flop synchronizer; resets to all-ones so active-low lines read as released.
module key_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/decimal_key_encoder.sv
// decimal_key_encoder: debounced one-of-ten to BCD priority encoder, one handshake per press.
module decimal_key_encoder
  import bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] key_n,
  output logic [BCD_W-1:0]      bcd,
  output logic                  valid,
  input  logic                  ready,
  output logic                  multi,
  output logic                  busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [NUM_DIGITS-1:0] key_s;
  logic [NUM_DIGITS-1:0] pressed;
  logic [BCD_W-1:0]      code;
  logic [BCD_W-1:0]      cand;
  logic [CW-1:0]         cnt;
  logic                  any;
  logic                  many;
  state_t                state;
  key_sync #(.W(NUM_DIGITS)) u_sync (.clk(clk), .rst(rst), .d(key_n), .q(key_s));
  always_comb begin
    pressed = ~key_s;
    any     = |pressed;
    many    = (pressed & (pressed - NUM_DIGITS'(1))) != '0;
    code    = prio_encode(pressed);
  end
  assign busy = state != IDLE;
  // cnt only advances while below DC, so it saturates rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      bcd   <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any) begin
          cand <= code;
          cnt  <= ONE;
          if (DEBOUNCE_CYCLES == 1) begin
            bcd   <= code;
            multi <= many;
            valid <= 1'b1;
            state <= PRESENT;
          end else state <= DEBOUNCE;
        end
        DEBOUNCE: if (!any) begin
          cnt   <= '0;
          state <= IDLE;
        end else if (code != cand) begin
          cand <= code;
          cnt  <= ONE;
        end else if (cnt + ONE >= DC) begin
          cnt   <= DC;
          bcd   <= cand;
          multi <= many;
          valid <= 1'b1;
          state <= PRESENT;
        end else cnt <= cnt + ONE;
        PRESENT: if (ready) begin
          valid <= 1'b0;
          cnt   <= '0;
          state <= RELEASE;
        end
        RELEASE: if (any) cnt <= '0;
        else if (cnt + ONE >= DC) begin
          cnt   <= '0;
          state <= IDLE;
        end else cnt <= cnt + ONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decimal_key_encoder.sv
// tb_decimal_key_encoder: directed presses with a scoreboard queue checked by a handshake monitor.
module tb_decimal_key_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_n = '1;
  logic [3:0] bcd;
  logic       valid;
  logic       ready = 1'b1;
  logic       multi;
  logic       busy;
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  decimal_key_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .bcd(bcd),
    .valid(valid), .ready(ready), .multi(multi), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      logic [4:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got bcd=%0d multi=%0d expected no transfer", bcd, multi);
      end else begin
        e = exp_q.pop_front();
        if ({bcd, multi} != e) begin
          errors++;
          $display("FAIL transfer: got bcd=%0d multi=%0d expected bcd=%0d multi=%0d",
                   bcd, multi, e[4:1], e[0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n;
    logic saw_valid, saw_busy, stable;
    tick(3);
    chk("reset_valid", int'(valid), 0);
    chk("reset_bcd", int'(bcd), 0);
    chk("reset_multi", int'(multi), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick(2);
    // single key 7, ready held high
    key_n[7] = 1'b0;
    exp_q.push_back({4'd7, 1'b0});
    wait_valid("press7", n);
    chk("latency7", n, 6);
    tick(1);
    chk("valid_one_cycle", int'(valid), 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      saw_valid |= valid;
    end
    chk("no_repeat", int'(saw_valid), 0);
    key_n = '1;
    tick(12);
    chk("idle_after_release", int'(busy), 0);
    // glitch of 3 cycles on key 3
    key_n[3] = 1'b0;
    saw_valid = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) key_n = '1;
      tick(1);
      saw_valid |= valid;
      saw_busy |= busy;
    end
    chk("glitch_no_valid", int'(saw_valid), 0);
    chk("glitch_busy_pulse", int'(saw_busy), 1);
    chk("glitch_busy_end", int'(busy), 0);
    // keys 2 and 9 together
    key_n[2] = 1'b0;
    key_n[9] = 1'b0;
    exp_q.push_back({4'd9, 1'b1});
    wait_valid("press29", n);
    tick(1);
    key_n = '1;
    tick(12);
    // consumer stalled on 5; a short press of 8 meanwhile is ignored
    ready = 1'b0;
    key_n[5] = 1'b0;
    exp_q.push_back({4'd5, 1'b0});
    wait_valid("press5", n);
    key_n = '1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) key_n[8] = 1'b0;
      if (i == 6) key_n = '1;
      tick(1);
      if (!(valid && bcd == 4'd5 && !multi)) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    ready = 1'b1;
    tick(1);
    chk("drop_after_ready", int'(valid), 0);
    tick(15);
    chk("idle_after_stall", int'(busy), 0);
    // key 1 for two cycles then switch to key 6
    key_n[1] = 1'b0;
    tick(2);
    key_n = '1;
    key_n[6] = 1'b0;
    exp_q.push_back({4'd6, 1'b0});
    wait_valid("switch6", n);
    chk("latency_switch", n, 6);
    tick(1);
    key_n = '1;
    tick(12);
    // reset while a code is pending
    ready = 1'b0;
    key_n[4] = 1'b0;
    wait_valid("press4", n);
    chk("pending_before_reset", int'(valid), 1);
    key_n = '1;
    rst = 1'b1;
    tick(1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_bcd", int'(bcd), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_multi", int'(multi), 0);
    rst = 1'b0;
    ready = 1'b1;
    tick(2);
    key_n[3] = 1'b0;
    exp_q.push_back({4'd3, 1'b0});
    wait_valid("press3", n);
    chk("latency3", n, 6);
    tick(1);
    key_n = '1;
    tick(12);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
